// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage stall/refill controller: FSM state encoding and
// line-offset helpers.
package mem_stall_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StFill  = 3'd3,
    StAbort = 3'd4
  } state_e;

  localparam int unsigned DefaultDataW = 128;

  // Byte-offset bits inside one refill line.
  function automatic int unsigned line_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  localparam int unsigned LineOffW = line_off_w(DefaultDataW);

endpackage

// File: rtl/mem_refill_timer.sv
// Watchdog counter for one outstanding refill: cleared when the request is accepted,
// counts WAIT cycles and flags the last allowed cycle.
module mem_refill_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      // Hold at the last value so the counter never wraps past expiry.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM->WB sequencing: stalls the pipe across D-cache line refills, kills the MEM instruction
// on exception or refill timeout, and counts stall cycles.
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_is_load,
  input  logic              mem_is_store,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              dcache_hit,
  input  logic              exc_in,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              stall_hold,
  output logic              kill_wb,
  output logic              bus_err,
  output logic [31:0]       stall_cycles
);

  localparam int unsigned OffW = line_off_w(DATA_W);
  localparam logic [ADDR_W-1:0] LineMask = {{(ADDR_W - OffW){1'b1}}, {OffW{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic miss;
  logic timer_clr;
  logic timer_inc;
  logic timer_expired;

  assign miss = mem_valid & (mem_is_load | mem_is_store) & ~dcache_hit & ~exc_in;

  assign timer_clr = (state_q == StReq) & mem_req_ready;
  assign timer_inc = (state_q == StWait);

  mem_refill_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (timer_clr),
    .inc_i    (timer_inc),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!(mem_valid && exc_in) && miss) state_d = StReq;
      StReq:   if (mem_req_ready) state_d = StWait;
      StWait: begin
        // A response in the expiry cycle still completes the refill.
        if (mem_resp_valid) begin
          state_d = StFill;
        end else if (timer_expired) begin
          state_d = StAbort;
        end
      end
      StFill:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d         = addr_q;
    data_d         = data_q;
    bus_err_d      = bus_err_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == StIdle && miss) begin
      addr_d = mem_addr & LineMask;
    end
    if (state_q == StWait && mem_resp_valid) begin
      data_d = mem_resp_data;
    end
    if (state_q == StAbort) begin
      bus_err_d = 1'b1;
    end
    if (stall_hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      data_q         <= '0;
      bus_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      bus_err_q      <= bus_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    stall_hold = 1'b0;
    kill_wb    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle:  begin
          stall_hold = miss;
          kill_wb    = mem_valid & exc_in;
        end
        StReq, StWait, StFill: stall_hold = 1'b1;
        StAbort: kill_wb = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_req_valid = (state_q == StReq);
  assign mem_req_addr  = addr_q;
  assign fill_we       = (state_q == StFill);
  assign fill_addr     = addr_q;
  assign fill_data     = data_q;
  assign bus_err       = bus_err_q;
  assign stall_cycles  = stall_cycles_q;

endmodule
